// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one memory request outstanding
// and buffers the returned entry toward decode. Optional response watchdog: IF_RSP_TIMEOUT_EN.
module if_fetch_ctrl #(
    parameter int                  PC_WIDTH       = 32,
    parameter int                  INSTR_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   mem_req_o,
    output logic [PC_WIDTH-1:0]    mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_instr_i,
    input  logic                   mem_rsp_err_i,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic                   if_pc_misalign_o,
    output logic                   if_bus_err_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD, HALT} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    buf_pc_q;
    logic [INSTR_WIDTH-1:0] buf_instr_q, ld_instr;
    logic                   buf_mis_q, buf_err_q;
    logic                   ld, ld_mis, ld_err;
    logic                   misaligned;
    logic                   timeout;

    assign misaligned = (pc_q[1:0] != 2'b00);

`ifdef IF_RSP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             waiting;

    assign waiting = (state_q == WAIT) || (state_q == DROP);
    assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restart the watchdog on every entry into a waiting state; a redirect within DROP keeps counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_d == WAIT || state_d == DROP) && (state_d != state_q)) begin
            cnt_q <= '0;
        end else if (waiting) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mem_req_o = 1'b0;
        ld        = 1'b0;
        ld_instr  = '0;
        ld_mis    = 1'b0;
        ld_err    = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (misaligned) begin
                    ld      = 1'b1;
                    ld_mis  = 1'b1;
                    state_d = HOLD;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    ld       = 1'b1;
                    ld_instr = mem_rsp_instr_i;
                    ld_err   = mem_rsp_err_i;
                    state_d  = HOLD;
                end else if (timeout) begin
                    ld      = 1'b1;
                    ld_err  = 1'b1;
                    state_d = HOLD;
                end
            end
            DROP: if (mem_rsp_valid_i || timeout) state_d = REQ;
            HOLD: begin
                if (if_ready_i) begin
                    if (buf_mis_q || buf_err_q) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + PC_WIDTH'(4);
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        // A granted-but-unanswered request must still be drained, hence DROP.
        if (redirect_valid_i && (state_q != IDLE)) begin
            pc_d = redirect_pc_i;
            ld   = 1'b0;
            case (state_q)
                REQ:       state_d = (mem_req_o && mem_gnt_i) ? DROP : REQ;
                WAIT, DROP: state_d = (mem_rsp_valid_i || timeout) ? REQ : DROP;
                default:   state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            buf_mis_q   <= 1'b0;
            buf_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ld) begin
                buf_pc_q    <= pc_q;
                buf_instr_q <= ld_instr;
                buf_mis_q   <= ld_mis;
                buf_err_q   <= ld_err;
            end
        end
    end

    assign mem_addr_o       = pc_q;
    assign if_valid_o       = (state_q == HOLD);
    assign if_pc_o          = buf_pc_q;
    assign if_instr_o       = buf_instr_q;
    assign if_pc_misalign_o = buf_mis_q;
    assign if_bus_err_o     = buf_err_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a behavioural memory answers grants, accepted decode
// entries are collected and compared against expectations queued as stimulus is applied.
module tb_if_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_instr_i = '0;
    logic        mem_rsp_err_i = 1'b0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_pc_misalign_o;
    logic        if_bus_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    bit          gnt_en = 1'b1;
    bit          rsp_en = 1'b1;
    int          rsp_lat = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wcnt = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          cyc = 0;

    ent_t        exp_q[$];
    ent_t        obs_q[$];
    int          obs_cyc[$];
    logic [31:0] gnt_q[$];

    if_fetch_ctrl #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_instr_i(mem_rsp_instr_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .if_pc_misalign_o(if_pc_misalign_o),
        .if_bus_err_o(if_bus_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic mis, input logic err);
        ent_t e;
        e.pc = pc; e.instr = ins; e.mis = mis; e.err = err;
        return e;
    endfunction

    // One clock: memory reacts at the falling edge, accepted entries are recorded there too.
    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_gnt_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i = 1'b0;
        mem_rsp_instr_i = '0;
        if (pend) begin
            if (rsp_en) begin
                if (wcnt == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_instr_i = instr_of(pend_addr);
                    mem_rsp_err_i = err_en && (pend_addr == err_addr);
                    pend = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end else if (mem_req_o && gnt_en) begin
            mem_gnt_i = 1'b1;
            pend = 1'b1;
            pend_addr = mem_addr_o;
            wcnt = rsp_lat - 1;
            gnt_q.push_back(mem_addr_o);
        end
        if (if_valid_o && if_ready_i && !redirect_valid_i) begin
            obs_q.push_back(mk(if_pc_o, if_instr_o, if_pc_misalign_o, if_bus_err_o));
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n, input int budget, output bit expired);
        for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
        expired = (obs_q.size() < n);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i = pc;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || if_valid_o !== 1'b0 ||
            if_pc_o !== 32'h0 || if_instr_o !== 32'h0 || if_pc_misalign_o !== 1'b0 ||
            if_bus_err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b addr=%h vld=%b pc=%h instr=%h mis=%b err=%b required all zero",
                     mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_instr_o, if_pc_misalign_o, if_bus_err_o);
        end
        rst_n = 1'b1;
        if_ready_i = 1'b1;
        n_checks++;
        if (mem_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_req: got %b required 0", mem_req_o);
        end
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL first_req: req=%b addr=%h required 1 / 00000000", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_sequential();
        bit   expired;
        ent_t e, o;
        obs_q.delete(); obs_cyc.delete(); gnt_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'(4 * i), instr_of(32'(4 * i)), 1'b0, 1'b0));
        run_until(3, 40, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL seq_timeout: got %0d entries required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.pc !== e.pc || o.instr !== e.instr || o.mis !== e.mis || o.err !== e.err) begin
                    n_errors++;
                    $display("FAIL seq_entry%0d: got pc=%h ins=%h mis=%b err=%b required pc=%h ins=%h mis=%b err=%b",
                             i, o.pc, o.instr, o.mis, o.err, e.pc, e.instr, e.mis, e.err);
                end
                n_checks++;
                if (gnt_q[i] !== e.pc) begin
                    n_errors++;
                    $display("FAIL seq_req_addr%0d: got %h required %h", i, gnt_q[i], e.pc);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
                    n_errors++;
                    $display("FAIL seq_spacing%0d: got %0d cycles required 3", i, obs_cyc[i] - obs_cyc[i-1]);
                end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        bit   expired;
        ent_t e, o;
        if_ready_i = 1'b0;
        for (int i = 0; i < 10 && !if_valid_o; i++) tick();
        n_checks++;
        if (if_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_valid: got %b required 1", if_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC || if_instr_o !== instr_of(32'hC) ||
                mem_req_o !== 1'b0 || mem_addr_o !== 32'hC) begin
                n_errors++;
                $display("FAIL stall_hold%0d: vld=%b pc=%h ins=%h req=%b addr=%h required 1/0000000c/%h/0/0000000c",
                         i, if_valid_o, if_pc_o, if_instr_o, mem_req_o, mem_addr_o, instr_of(32'hC));
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL stall_no_accept: got %0d entries required 0", obs_q.size());
        end
        if_ready_i = 1'b1;
        exp_q.push_back(mk(32'hC, instr_of(32'hC), 1'b0, 1'b0));
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL stall_accept_timeout: got 0 entries required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.pc !== e.pc || o.instr !== e.instr || o.mis !== e.mis || o.err !== e.err) begin
                n_errors++;
                $display("FAIL stall_entry: got pc=%h ins=%h required pc=%h ins=%h", o.pc, o.instr, e.pc, e.instr);
            end
        end
        n_checks++;
        if (mem_addr_o !== 32'h10 || mem_req_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_pc_advance: addr=%h req=%b required 00000010/1", mem_addr_o, mem_req_o);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_redirect_wait();
        bit   expired;
        ent_t o;
        rsp_lat = 2;
        tick();
        n_checks++;
        if (gnt_q.size() == 0 || gnt_q[$] !== 32'h10) begin
            n_errors++;
            $display("FAIL rdw_grant: got %0d grants required last 00000010", gnt_q.size());
        end
        redirect_to(32'h100);
        rsp_lat = 1;
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            n_errors++;
            $display("FAIL rdw_new_req: req=%b addr=%h required 1/00000100", mem_req_o, mem_addr_o);
        end
        exp_q.push_back(mk(32'h100, instr_of(32'h100), 1'b0, 1'b0));
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL rdw_timeout: got 0 entries required 1");
        end else begin
            o = obs_q.pop_front();
            if (o.pc !== exp_q[0].pc || o.instr !== exp_q[0].instr || o.err !== 1'b0) begin
                n_errors++;
                $display("FAIL rdw_entry: got pc=%h ins=%h required pc=%h ins=%h",
                         o.pc, o.instr, exp_q[0].pc, exp_q[0].instr);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_misalign();
        bit   expired;
        int   gcount;
        bit   bad;
        ent_t o;
        redirect_to(32'h102);
        gcount = gnt_q.size();
        exp_q.push_back(mk(32'h102, 32'h0, 1'b1, 1'b0));
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL mis_timeout: got 0 entries required 1");
        end else begin
            o = obs_q.pop_front();
            if (o.pc !== 32'h102 || o.instr !== 32'h0 || o.mis !== 1'b1 || o.err !== 1'b0) begin
                n_errors++;
                $display("FAIL mis_entry: got pc=%h ins=%h mis=%b err=%b required 00000102/0/1/0",
                         o.pc, o.instr, o.mis, o.err);
            end
        end
        n_checks++;
        if (gnt_q.size() != gcount) begin
            n_errors++;
            $display("FAIL mis_no_req: got %0d grants required %0d", gnt_q.size(), gcount);
        end
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (mem_req_o !== 1'b0 || if_valid_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL mis_halt: got activity in HALT required req=0 vld=0");
        end
        exp_q.delete();
        redirect_to(32'h200);
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL mis_resume_timeout: got 0 entries required 1");
        end else begin
            o = obs_q.pop_front();
            if (o.pc !== 32'h200 || o.instr !== instr_of(32'h200) || o.mis !== 1'b0) begin
                n_errors++;
                $display("FAIL mis_resume_entry: got pc=%h ins=%h required 00000200/%h",
                         o.pc, o.instr, instr_of(32'h200));
            end
        end
        obs_q.delete();
    endtask

    task automatic test_bus_err();
        bit   expired;
        int   gcount;
        bit   bad;
        ent_t e, o;
        err_en = 1'b1;
        err_addr = 32'h8;
        redirect_to(32'h8);
        exp_q.push_back(mk(32'h8, instr_of(32'h8), 1'b0, 1'b1));
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL err_timeout: got 0 entries required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.pc !== e.pc || o.instr !== e.instr || o.mis !== e.mis || o.err !== e.err) begin
                n_errors++;
                $display("FAIL err_entry: got pc=%h ins=%h mis=%b err=%b required pc=%h ins=%h mis=%b err=%b",
                         o.pc, o.instr, o.mis, o.err, e.pc, e.instr, e.mis, e.err);
            end
        end
        gcount = gnt_q.size();
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (mem_req_o !== 1'b0 || if_valid_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || gnt_q.size() != gcount) begin
            n_errors++;
            $display("FAIL err_halt: got grants=%0d activity=%b required grants=%0d activity=0",
                     gnt_q.size(), bad, gcount);
        end
        err_en = 1'b0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        bit   expired;
        bit   bad;
        ent_t o;
        rsp_en = 1'b0;
        redirect_to(32'h300);
        tick();
        n_checks++;
        if (gnt_q.size() == 0 || gnt_q[$] !== 32'h300) begin
            n_errors++;
            $display("FAIL to_grant: got %0d grants required last 00000300", gnt_q.size());
        end
`ifdef IF_RSP_TIMEOUT_EN
        repeat (15) tick();
        n_checks++;
        if (if_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL to_early: vld=%b after 15 cycles required 0", if_valid_o);
        end
        tick();
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h300 || if_instr_o !== 32'h0 ||
            if_bus_err_o !== 1'b1 || if_pc_misalign_o !== 1'b0) begin
            n_errors++;
            $display("FAIL to_entry: vld=%b pc=%h ins=%h err=%b mis=%b required 1/00000300/0/1/0",
                     if_valid_o, if_pc_o, if_instr_o, if_bus_err_o, if_pc_misalign_o);
        end
        pend = 1'b0;
        rsp_en = 1'b1;
        exp_q.push_back(mk(32'h300, 32'h0, 1'b0, 1'b1));
`else
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL to_wait_forever: got activity while waiting required none");
        end
        rsp_en = 1'b1;
        exp_q.push_back(mk(32'h300, instr_of(32'h300), 1'b0, 1'b0));
`endif
        run_until(1, 10, expired);
        n_checks++;
        if (expired) begin
            n_errors++;
            $display("FAIL to_accept_timeout: got 0 entries required 1");
        end else begin
            o = obs_q.pop_front();
            if (o.pc !== exp_q[0].pc || o.instr !== exp_q[0].instr || o.err !== exp_q[0].err) begin
                n_errors++;
                $display("FAIL to_final_entry: got pc=%h ins=%h err=%b required pc=%h ins=%h err=%b",
                         o.pc, o.instr, o.err, exp_q[0].pc, exp_q[0].instr, exp_q[0].err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_misalign();
        test_bus_err();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch sequencer between the PC/redirect logic and the instruction memory port. It owns the fetch PC register, issues one outstanding fetch request at a time over a req/gnt/rsp handshake, and registers the returned instruction toward decode with a valid/ready handshake. It handles redirects (branch/exception flush), including discarding an in-flight response, and it raises PC-misalign and bus-error status alongside the instruction.

Parameters:
PC_WIDTH, 32, width of fetch PC and memory address
INSTR_WIDTH, 32, width of instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset
TIMEOUT_CYCLES, 16, response watchdog limit (used only with IF_RSP_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
redirect_valid_i  in  1  flush current fetch and restart at redirect_pc_i
redirect_pc_i  in  PC_WIDTH  new fetch PC
mem_req_o  out  1  fetch request valid
mem_addr_o  out  PC_WIDTH  fetch address (= pc_q)
mem_gnt_i  in  1  memory accepted request this cycle
mem_rsp_valid_i  in  1  response valid (≥1 cycle after gnt)
mem_rsp_instr_i  in  INSTR_WIDTH  returned instruction
mem_rsp_err_i  in  1  bus error on response
if_valid_o  out  1  instruction entry valid toward decode
if_ready_i  in  1  decode accepts entry
if_pc_o  out  PC_WIDTH  PC of entry
if_instr_o  out  INSTR_WIDTH  instruction of entry
if_pc_misalign_o  out  1  entry PC had pc[1:0] != 0
if_bus_err_o  out  1  entry response carried error (or timeout)

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, state=IDLE, all outputs 0 (mem_addr_o=RESET_PC). Output buffer cleared.
- States: IDLE, REQ, WAIT, DROP, HOLD, HALT. Encoding free; one-hot not required.
- IDLE: exactly one cycle after reset release -> REQ.
- REQ: if pc_q[1:0]!=0, no request; load buffer {pc_q, instr=0, misalign=1, err=0} -> HOLD. Otherwise mem_req_o=1; on mem_gnt_i -> WAIT; else stay (addr held stable).
- WAIT: mem_req_o=0; on mem_rsp_valid_i, load buffer {pc_q, rsp_instr, 0, rsp_err} -> HOLD. Response is registered, never forwarded combinationally; min gnt-to-if_valid_o latency = rsp latency + 1.
- HOLD: if_valid_o=1; buffer stable while if_ready_i=0. On if_ready_i: if misalign or err -> HALT; else pc_q<=pc_q+4 (wraps mod 2^PC_WIDTH) -> REQ. Max throughput: one instruction per 3 cycles at 1-cycle memory latency.
- HALT: idle, no requests, if_valid_o=0; exits only via redirect.
- Redirect (highest priority, any state except IDLE): pc_q<=redirect_pc_i; if_valid_o deasserts next cycle (entry dropped even if if_ready_i same cycle); next state REQ, except WAIT without same-cycle rsp -> DROP. Redirect in REQ with same-cycle gnt -> DROP (request counts as outstanding).
- DROP: wait for mem_rsp_valid_i, discard it, -> REQ. Redirect in DROP updates pc_q, stays DROP (rsp same cycle -> REQ).
- At most one request outstanding; mem_req_o never asserted in WAIT/DROP/HOLD/HALT.

Optional Feature:
IF_RSP_TIMEOUT_EN: defined -> counter cleared on entering WAIT/DROP, increments each cycle waiting; at TIMEOUT_CYCLES in WAIT, load buffer {pc_q, 0, 0, err=1} -> HOLD; in DROP, -> REQ. A late response after a timeout is not tracked (memory must not respond). Undefined -> no counter; WAIT/DROP wait indefinitely.

Test Plan:
- Reset release, 1-cycle memory, if_ready_i=1 -> requests at 0x0,0x4,0x8; if_pc_o sequence 0x0,0x4,0x8 with matching instr, one entry per 3 cycles.
- if_ready_i held 0 for 5 cycles in HOLD -> if_valid_o, if_pc_o, if_instr_o stable; no mem_req_o; pc advances only after accept.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response dropped, next mem_addr_o=0x100, no if_valid_o for old PC.
- Redirect to 0x102 -> no mem_req_o; entry pc=0x102, misalign=1; after accept HALT; redirect to 0x200 resumes fetch at 0x200.
- mem_rsp_err_i=1 on fetch at 0x8 -> entry err=1; after accept no further requests until redirect.
- With IF_RSP_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> entry err=1 after 16 waiting cycles; without macro, still in WAIT after 100 cycles.
